// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: drives an external 4-bit-in / 16-bit-out digit shift
// register from debounced keypad strobes, then checks the entered code and
// runs the unlock, wrong-code and lockout sequences.
// Optional feature macro: COMBO_LOCK_PROGRAM_EN (re-program the code while
// the lock is open). Without it the compare uses the CODE parameter and
// prog is ignored.
module combo_lock_ctrl #(
  parameter logic [15:0] CODE           = 16'h4321,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 500,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] sr_out,
  input  logic        prog,
  output logic [3:0]  sr_in,
  output logic        sr_trig,
  output logic        sr_rst,
  output logic        unlocked,
  output logic        fail,
  output logic        locked_out,
  output logic [2:0]  digit_cnt
);

  localparam int TRY_W  = $clog2(MAX_TRIES) + 1;
  localparam int OPEN_W = $clog2(UNLOCK_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_SETTLE  = 3'd3,
    S_CHECK   = 3'd4,
    S_OPEN    = 3'd5,
    S_CLEAR   = 3'd6,
    S_LOCKOUT = 3'd7
  } state_t;

  state_t              r_state;
  logic                r_key_prev;
  logic                w_key_rise;
  logic [3:0]          r_sr_in;
  logic                r_sr_trig;
  logic                r_sr_rst;
  logic                r_unlocked;
  logic                r_fail;
  logic                r_locked_out;
  logic [2:0]          r_digit_cnt;
  logic [TRY_W-1:0]    r_try_cnt;
  logic [OPEN_W-1:0]   r_open_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [15:0]         w_code;

`ifdef COMBO_LOCK_PROGRAM_EN
  logic [15:0]         r_code;
  logic                r_prog_flag;
  assign w_code = r_code;
`else
  logic                w_unused_prog;
  assign w_unused_prog = prog;
  assign w_code        = CODE;
`endif

  // Remember the previous key_valid level so each press is taken only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_prev <= 1'b0;
    end else begin
      r_key_prev <= key_valid;
    end
  end

  assign w_key_rise = key_valid & ~r_key_prev;

  // Main sequencer: state, attempt/timer counters and all registered outputs.
  // Every entry into S_CLEAR raises sr_rst and zeroes digit_cnt on the same
  // edge so the clear strobe is visible for exactly the S_CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sr_in      <= 4'h0;
      r_sr_trig    <= 1'b0;
      r_sr_rst     <= 1'b1;
      r_unlocked   <= 1'b0;
      r_fail       <= 1'b0;
      r_locked_out <= 1'b0;
      r_digit_cnt  <= 3'd0;
      r_try_cnt    <= {TRY_W{1'b0}};
      r_open_cnt   <= {OPEN_W{1'b0}};
      r_lock_cnt   <= {LOCK_W{1'b0}};
`ifdef COMBO_LOCK_PROGRAM_EN
      r_code       <= CODE;
      r_prog_flag  <= 1'b0;
`endif
    end else begin
      r_sr_trig <= 1'b0;
      r_sr_rst  <= 1'b0;
      r_fail    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_key_rise) begin
            if (key_code <= 4'h9) begin
              r_sr_in <= key_code;
              r_state <= S_LOAD;
            end else if (key_code == 4'hF) begin
              // Clear key: also abandons a pending code-program operation.
              r_sr_rst    <= 1'b1;
              r_digit_cnt <= 3'd0;
              r_state     <= S_CLEAR;
`ifdef COMBO_LOCK_PROGRAM_EN
              r_prog_flag <= 1'b0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          // sr_in has been stable for a full cycle; strobe it in next.
          r_sr_trig <= 1'b1;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_digit_cnt <= r_digit_cnt + 3'd1;
          if (r_digit_cnt == 3'd3) begin
            r_state <= S_CHECK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
`ifdef COMBO_LOCK_PROGRAM_EN
          if (r_prog_flag) begin
            r_code      <= sr_out;
            r_prog_flag <= 1'b0;
            r_sr_rst    <= 1'b1;
            r_digit_cnt <= 3'd0;
            r_state     <= S_CLEAR;
          end else
`endif
          if (sr_out == w_code) begin
            r_unlocked <= 1'b1;
            r_try_cnt  <= {TRY_W{1'b0}};
            r_open_cnt <= OPEN_W'(UNLOCK_CYCLES - 1);
            r_state    <= S_OPEN;
          end else begin
            r_fail    <= 1'b1;
            r_try_cnt <= r_try_cnt + TRY_W'(1);
            if (r_try_cnt == TRY_W'(MAX_TRIES - 1)) begin
              r_locked_out <= 1'b1;
              r_lock_cnt   <= LOCK_W'(LOCKOUT_CYCLES - 1);
              r_state      <= S_LOCKOUT;
            end else begin
              r_sr_rst    <= 1'b1;
              r_digit_cnt <= 3'd0;
              r_state     <= S_CLEAR;
            end
          end
        end
        S_OPEN: begin
`ifdef COMBO_LOCK_PROGRAM_EN
          if (prog) begin
            r_prog_flag <= 1'b1;
            r_unlocked  <= 1'b0;
            r_sr_rst    <= 1'b1;
            r_digit_cnt <= 3'd0;
            r_state     <= S_CLEAR;
          end else
`endif
          if (r_open_cnt == {OPEN_W{1'b0}}) begin
            r_unlocked  <= 1'b0;
            r_sr_rst    <= 1'b1;
            r_digit_cnt <= 3'd0;
            r_state     <= S_CLEAR;
          end else begin
            r_open_cnt <= r_open_cnt - OPEN_W'(1);
          end
        end
        S_CLEAR: begin
          r_state <= S_IDLE;
        end
        S_LOCKOUT: begin
          if (r_lock_cnt == {LOCK_W{1'b0}}) begin
            r_locked_out <= 1'b0;
            r_try_cnt    <= {TRY_W{1'b0}};
            r_sr_rst     <= 1'b1;
            r_digit_cnt  <= 3'd0;
            r_state      <= S_CLEAR;
          end else begin
            r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sr_in      = r_sr_in;
  assign sr_trig    = r_sr_trig;
  assign sr_rst     = r_sr_rst;
  assign unlocked   = r_unlocked;
  assign fail       = r_fail;
  assign locked_out = r_locked_out;
  assign digit_cnt  = r_digit_cnt;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed bench for combo_lock_ctrl with a small model
// of the external digit shift register feeding sr_out.
module tb_combo_lock_ctrl;

  localparam int UNLOCK_C = 500;
  localparam int LOCK_C   = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] sr_model;
  logic        prog;
  logic [3:0]  sr_in;
  logic        sr_trig;
  logic        sr_rst;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  logic [2:0]  digit_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int trig_cnt = 0;
  int srst_cnt = 0;
  int fail_cnt = 0;
  int unl_cnt  = 0;
  int lo_cnt   = 0;

  combo_lock_ctrl #(
    .CODE(16'h4321),
    .MAX_TRIES(3),
    .UNLOCK_CYCLES(UNLOCK_C),
    .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .sr_out(sr_model),
    .prog(prog),
    .sr_in(sr_in),
    .sr_trig(sr_trig),
    .sr_rst(sr_rst),
    .unlocked(unlocked),
    .fail(fail),
    .locked_out(locked_out),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  // External shift register: clear on sr_rst, shift a nibble in on sr_trig.
  always @(posedge clk) begin
    if (sr_rst) sr_model <= 16'h0000;
    else if (sr_trig) sr_model <= {sr_model[11:0], sr_in};
  end

  // Count high cycles of the strobes and status outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (sr_trig)    trig_cnt <= trig_cnt + 1;
    if (sr_rst)     srst_cnt <= srst_cnt + 1;
    if (fail)       fail_cnt <= fail_cnt + 1;
    if (unlocked)   unl_cnt  <= unl_cnt + 1;
    if (locked_out) lo_cnt   <= lo_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One key press with the load/shift timing checked: trig two cycles after the rise.
  task automatic press_key(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    tick(1);
    check_eq("load_trig_low", int'(sr_trig), 0);
    check_eq("load_sr_in", int'(sr_in), int'(code));
    tick(1);
    check_eq("shift_trig_high", int'(sr_trig), 1);
    check_eq("shift_sr_in", int'(sr_in), int'(code));
    tick(1);
    check_eq("settle_trig_low", int'(sr_trig), 0);
    key_valid = 1'b0;
  endtask

  task automatic tap_key(input logic [3:0] code, input int hold);
    key_code  = code;
    key_valid = 1'b1;
    tick(hold);
    key_valid = 1'b0;
    tick(2);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      press_key(c[15-4*i -: 4]);
      if (i < 3) begin
        tick(10);
        check_eq("digit_cnt_step", int'(digit_cnt), i + 1);
      end
    end
  endtask

  // Wait for the unlock window and check its length and the clear after it.
  task automatic expect_unlock();
    int t;
    int n;
    t = 0;
    while (!unlocked && t < 20) begin tick(1); t++; end
    check_eq("unlock_seen", int'(unlocked), 1);
    check_eq("open_digit_cnt", int'(digit_cnt), 4);
    n = 0;
    while (unlocked && n < 3000) begin n++; tick(1); end
    check_eq("unlock_len", n, UNLOCK_C);
    check_eq("open_end_sr_rst", int'(sr_rst), 1);
    tick(1);
    check_eq("clear_sr_rst_low", int'(sr_rst), 0);
    check_eq("clear_digit_cnt", int'(digit_cnt), 0);
  endtask

  task automatic expect_wrong(input logic [15:0] c, input int exp_lock);
    int fb;
    int ub;
    int sb;
    fb = fail_cnt; ub = unl_cnt; sb = srst_cnt;
    enter_code(c);
    tick(10);
    check_eq("wrong_fail_pulse", fail_cnt - fb, 1);
    check_eq("wrong_no_unlock", unl_cnt - ub, 0);
    check_eq("wrong_locked_out", int'(locked_out), exp_lock);
    if (exp_lock == 0) begin
      check_eq("wrong_sr_rst", srst_cnt - sb, 1);
      check_eq("wrong_digit_cnt", int'(digit_cnt), 0);
    end
  endtask

  initial begin
    int tb_base;
    int lb;
    int sb;
    int t;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; prog = 1'b0;
    tick(3);
    // Reset state
    check_eq("rst_unlocked", int'(unlocked), 0);
    check_eq("rst_fail", int'(fail), 0);
    check_eq("rst_locked_out", int'(locked_out), 0);
    check_eq("rst_digit_cnt", int'(digit_cnt), 0);
    check_eq("rst_sr_trig", int'(sr_trig), 0);
    check_eq("rst_sr_in", int'(sr_in), 0);
    check_eq("rst_sr_rst", int'(sr_rst), 1);
    rst = 1'b0;
    tick(2);
    check_eq("post_rst_sr_rst", int'(sr_rst), 0);

    // Correct code 4,3,2,1
    tb_base = trig_cnt;
    enter_code(16'h4321);
    expect_unlock();
    check_eq("unlock_trig_count", trig_cnt - tb_base, 4);
    tick(5);

    // Wrong code 1,2,3,4 then two more wrong codes -> lockout
    expect_wrong(16'h1234, 0);
    expect_wrong(16'h5555, 0);
    lb = lo_cnt;
    expect_wrong(16'h0000, 1);
    tb_base = trig_cnt;
    tap_key(4'h4, 5);
    tap_key(4'h3, 5);
    tap_key(4'hF, 5);
    tap_key(4'h1, 5);
    t = 0;
    while (locked_out && t < 3000) begin tick(1); t++; end
    check_eq("lockout_ended", int'(locked_out), 0);
    check_eq("lockout_len", lo_cnt - lb, LOCK_C);
    check_eq("lockout_keys_ignored", trig_cnt - tb_base, 0);
    check_eq("lockout_end_sr_rst", int'(sr_rst), 1);
    tick(3);
    enter_code(16'h4321);
    expect_unlock();
    tick(5);

    // 4,3 then clear, then the full code
    press_key(4'h4); tick(5);
    press_key(4'h3); tick(5);
    check_eq("pre_clear_cnt", int'(digit_cnt), 2);
    sb = srst_cnt;
    tap_key(4'hF, 3);
    check_eq("clear_key_sr_rst", srst_cnt - sb, 1);
    check_eq("clear_key_cnt", int'(digit_cnt), 0);
    sb = srst_cnt;
    tap_key(4'hF, 3);
    check_eq("clear_empty_sr_rst", srst_cnt - sb, 1);
    enter_code(16'h4321);
    expect_unlock();
    tick(5);

    // Held key, ignored codes, keys while open, reset while open
    tb_base = trig_cnt;
    tap_key(4'h4, 50);
    check_eq("held_key_one_trig", trig_cnt - tb_base, 1);
    check_eq("held_key_cnt", int'(digit_cnt), 1);
    tb_base = trig_cnt;
    tap_key(4'hA, 3);
    tap_key(4'hE, 3);
    check_eq("ignored_codes_trig", trig_cnt - tb_base, 0);
    check_eq("ignored_codes_cnt", int'(digit_cnt), 1);
    tap_key(4'hF, 3);
    enter_code(16'h4321);
    tick(4);
    check_eq("open_before_rst", int'(unlocked), 1);
    tb_base = trig_cnt;
    tap_key(4'h7, 3);
    check_eq("open_keys_ignored", trig_cnt - tb_base, 0);
    #3 rst = 1'b1;
    #1;
    check_eq("rst_open_unlocked", int'(unlocked), 0);
    check_eq("rst_open_digit_cnt", int'(digit_cnt), 0);
    check_eq("rst_open_sr_rst", int'(sr_rst), 1);
    tick(2);
    rst = 1'b0;
    tick(2);

`ifdef COMBO_LOCK_PROGRAM_EN
    // Program a new code 9876 from the open state
    enter_code(16'h4321);
    tick(5);
    check_eq("prog_open", int'(unlocked), 1);
    prog = 1'b1;
    tick(1);
    prog = 1'b0;
    check_eq("prog_exit_unlocked", int'(unlocked), 0);
    check_eq("prog_exit_sr_rst", int'(sr_rst), 1);
    tick(3);
    lb = fail_cnt;
    sb = unl_cnt;
    enter_code(16'h9876);
    tick(10);
    check_eq("prog_no_fail", fail_cnt - lb, 0);
    check_eq("prog_no_unlock", unl_cnt - sb, 0);
    check_eq("prog_digit_cnt", int'(digit_cnt), 0);
    expect_wrong(16'h4321, 0);
    enter_code(16'h9876);
    expect_unlock();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequencing controller for the 4-bit-in / 16-bit-out digit shift register in the combo-lock design. It takes debounced keypad digits, drives the register's data, trigger and reset inputs, and counts entered digits. After the fourth digit it compares the register's 16-bit output against the stored code. It then sequences unlock, failure and lockout behaviour.

Parameters:
CODE, 16'h4321, default unlock code; nibble [15:12] is the first digit entered, [3:0] the last.
MAX_TRIES, 3, consecutive wrong codes that trigger lockout (1..15).
UNLOCK_CYCLES, 500, clock cycles the unlocked output stays high.
LOCKOUT_CYCLES, 1000, clock cycles keypad input is ignored after MAX_TRIES failures.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
key_valid  input  1  debounced keypad strobe (level); a new key is taken on each 0->1 transition.
key_code  input  4  keypad value, stable while key_valid is high; 4'h0-4'h9 are digits, 4'hF is clear, others are ignored.
sr_out  input  16  shift register contents (newest digit in [3:0]).
prog  input  1  code-program request (used only with PROGRAM_EN).
sr_in  output  4  digit presented to the shift register.
sr_trig  output  1  shift strobe to the shift register.
sr_rst  output  1  clear strobe to the shift register.
unlocked  output  1  lock open.
fail  output  1  one-cycle pulse on a wrong code.
locked_out  output  1  lockout active.
digit_cnt  output  3  digits entered in the current attempt (0..4).

Behaviour:
- Reset values (asynchronous): state IDLE; sr_in=0, sr_trig=0, sr_rst=1 while rst is high and 0 after; unlocked=0, fail=0, locked_out=0, digit_cnt=0; try counter=0; key edge register=0.
- Key edge detection: key_valid is registered once. A rise is key_valid=1 with prev=0. Only one key is accepted per rise, and no repeat while the key is held.
- FSM states: IDLE, LOAD, SHIFT, SETTLE, CHECK, OPEN, CLEAR, LOCKOUT.
- IDLE, on a rise:
  - key_code<=9: latch the digit into sr_in, go to LOAD.
  - key_code==F: go to CLEAR.
  - other codes: ignored.
- LOAD: sr_in is stable for 1 cycle. Go to SHIFT.
- SHIFT: sr_trig=1 for exactly 1 cycle. sr_in is held. Go to SETTLE.
- SETTLE: 1 cycle with sr_trig=0 so the register output settles. digit_cnt increments. If the new count is 4, go to CHECK; otherwise go to IDLE.
- Latency from key rise to sr_trig high is 2 cycles (LOAD, then SHIFT).
- CHECK, one cycle, compares sr_out with the code:
  - Equal: unlocked=1, try counter=0, go to OPEN.
  - Not equal: fail pulses 1 cycle and the try counter increments. If the count reaches MAX_TRIES, locked_out=1 and go to LOCKOUT. Otherwise go to CLEAR.
- OPEN: held for UNLOCK_CYCLES cycles with keys ignored, then unlocked=0 and go to CLEAR.
- CLEAR: sr_rst=1 for 1 cycle and digit_cnt=0. Go to IDLE.
- LOCKOUT: a down-counter runs LOCKOUT_CYCLES cycles with all keys ignored. Then locked_out=0, try counter=0, go to CLEAR.
- Key rises outside IDLE are discarded, not queued.
- A clear key with digit_cnt=0 still pulses sr_rst.
- Mid-operation reset returns everything to reset values immediately, including unlocked and locked_out.
- Counters are sized with $clog2 of their parameter plus 1. They never wrap, because each saturates at its terminal value and exits the state.

Optional Feature:
- Macro: COMBO_LOCK_PROGRAM_EN.
- Defined:
  - An internal 16-bit code register is loaded from CODE at reset.
  - A prog pulse while in OPEN ends the unlock window and enters CLEAR with a program flag set.
  - The next 4 digits are shifted normally. CHECK then stores sr_out into the code register instead of comparing, and the flag clears.
  - unlocked stays 0 during programming. fail does not pulse during programming.
  - A clear key during programming abandons the operation and keeps the old code.
- Undefined: the compare always uses the CODE parameter, and prog is ignored.

Test Plan:
- Reset, then keys 4,3,2,1 with 10-cycle gaps -> four sr_trig pulses, each 2 cycles after its key rise with sr_in stable; unlocked=1 for exactly 500 cycles; then sr_rst pulses and digit_cnt=0.
- Keys 1,2,3,4 -> fail pulses once, unlocked stays 0, sr_rst pulses, try counter=1.
- Three wrong 4-digit codes -> locked_out=1; keys during the next 1000 cycles produce no sr_trig; then locked_out=0 and a correct 4321 unlocks.
- Keys 4,3 then F then 4,3,2,1 -> sr_rst after the F, digit_cnt returns to 0, and the final entry unlocks.
- Key 4 held high for 50 cycles -> exactly one sr_trig; keys 4'hA/4'hE produce no sr_trig; asserting rst in OPEN drops unlocked in the same cycle.
- With COMBO_LOCK_PROGRAM_EN: unlock with 4321, pulse prog, enter 9,8,7,6 -> 4321 then fails and 9876 unlocks.
